// File: rtl/csa_pkg.sv
// Shared types and helpers for the carry-save accumulator: FSM states,
// default geometry, and the chunk-width sanity check used at elaboration.
package csa_pkg;

  typedef enum logic [1:0] {
    S_ACC     = 2'd0,
    S_RESOLVE = 2'd1,
    S_OUT     = 2'd2
  } state_t;

  localparam int W_DEF     = 24;
  localparam int CW_DEF    = 8;
  localparam int CHUNK_DEF = 8;
  localparam int A         = W_DEF + CW_DEF;
  localparam int NCH       = A / CHUNK_DEF;

  function automatic bit width_ok(input int a_w, input int chunk_w);
    return (chunk_w > 0) && ((a_w % chunk_w) == 0);
  endfunction

endpackage

// File: rtl/csa_row.sv
// One row of 3:2 compressors: bitwise sum plus the majority carry shifted
// up one place. The carry out of the top bit is intentionally discarded.
module csa_row #(
  parameter int A = 32
) (
  input  logic [A-1:0] a,
  input  logic [A-1:0] b,
  input  logic [A-1:0] c,
  output logic [A-1:0] ps,
  output logic [A-1:0] cs
);

  logic [A-2:0] w_maj;

  always_comb begin
    ps    = a ^ b ^ c;
    w_maj = (a[A-2:0] & b[A-2:0]) | (a[A-2:0] & c[A-2:0]) | (b[A-2:0] & c[A-2:0]);
    cs    = {w_maj, 1'b0};
  end

endmodule

// File: rtl/csa_accum.sv
// Streaming packet accumulator: operands fold into a redundant sum/carry pair
// in ACC, then a CHUNK-bit ripple resolves the pair over NCH cycles.
//
// state     | meaning
// S_ACC     | accepting operands, compressing into r_s/r_c
// S_RESOLVE | adding slice r_k of r_s + r_c with carry r_cy into r_res
// S_OUT     | result presented, waiting for out_ready
module csa_accum
  import csa_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int CW    = CW_DEF,
  parameter int CHUNK = CHUNK_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W+CW-1:0]   out_data,
  output logic [CW:0]       out_count,
  output logic              out_ovf
);

  localparam int AW = W + CW;
  localparam int NC = AW / CHUNK;
  localparam int KW = (NC > 1) ? $clog2(NC) : 1;
  localparam logic [CW:0]   CNT_MAX = '1;
  localparam logic [CW:0]   OVF_AT  = (CW+1)'((1 << CW) + 1);
  localparam logic [KW-1:0] K_LAST  = KW'(NC - 1);

  if (!width_ok(AW, CHUNK)) begin : g_bad_chunk
    $error("csa_accum: accumulator width must be a multiple of CHUNK");
  end

  state_t          r_state;
  logic [AW-1:0]   r_s;
  logic [AW-1:0]   r_c;
  logic [AW-1:0]   r_res;
  logic [CW:0]     r_count;
  logic [KW-1:0]   r_k;
  logic            r_cy;
  logic            r_ovf;
  logic            r_in_ready;
  logic            r_out_valid;

  logic [AW-1:0]   w_x;
  logic [AW-1:0]   w_ps;
  logic [AW-1:0]   w_cs;
  logic [CHUNK:0]  w_sum;
  logic [CW:0]     w_cnt_next;

  csa_row #(.A(AW)) u_row (
    .a  (r_s),
    .b  (r_c),
    .c  (w_x),
    .ps (w_ps),
    .cs (w_cs)
  );

  always_comb begin
    w_x        = {{CW{1'b0}}, in_data};
    w_sum      = {1'b0, r_s[r_k*CHUNK +: CHUNK]} + {1'b0, r_c[r_k*CHUNK +: CHUNK]}
               + {{CHUNK{1'b0}}, r_cy};
    w_cnt_next = (r_count == CNT_MAX) ? r_count : r_count + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_ACC;
      r_s         <= '0;
      r_c         <= '0;
      r_res       <= '0;
      r_count     <= '0;
      r_k         <= '0;
      r_cy        <= 1'b0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_ACC: begin
          if (in_valid && r_in_ready) begin
            r_s     <= w_ps;
            r_c     <= w_cs;
            r_count <= w_cnt_next;
            // sticky once the packet exceeds the exact-sum operand budget
            if (w_cnt_next >= OVF_AT) r_ovf <= 1'b1;
            if (in_last) begin
              r_state    <= S_RESOLVE;
              r_k        <= '0;
              r_cy       <= 1'b0;
              r_in_ready <= 1'b0;
            end
          end
        end
        S_RESOLVE: begin
          r_res[r_k*CHUNK +: CHUNK] <= w_sum[CHUNK-1:0];
          r_cy                      <= w_sum[CHUNK];
          r_k                       <= r_k + 1'b1;
          if (r_k == K_LAST) begin
            r_state     <= S_OUT;
            r_out_valid <= 1'b1;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            r_s         <= '0;
            r_c         <= '0;
            r_count     <= '0;
            r_ovf       <= 1'b0;
            r_state     <= S_ACC;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_ACC;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_res;
  assign out_count = r_count;
  assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_csa_accum.sv
// Directed and randomized checks of csa_accum against a plain-arithmetic
// packet-sum model (sum mod 2^32, operand count, overflow past 256 operands).
module tb_csa_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [8:0]  out_count;
  logic        out_ovf;

  int tests = 0;
  int fails = 0;

  csa_accum #(.W(24), .CW(8), .CHUNK(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [23:0] d, input logic last);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      in_last  = 1'b1;
      in_data  = 24'($urandom);
      step();
    end
    in_last = 1'b0;
  endtask

  task automatic get_result(input int stall, output logic [31:0] d, output logic [8:0] cnt,
                            output logic ovf, output bit timeout);
    int n = 0;
    timeout = 0;
    while (!out_valid && n < 100) begin
      step();
      n++;
    end
    if (!out_valid) begin
      timeout = 1;
      d = 'x; cnt = 'x; ovf = 1'bx;
      return;
    end
    for (int i = 0; i < stall; i++) step();
    d   = out_data;
    cnt = out_count;
    ovf = out_ovf;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    tests++; if (in_ready !== 1'b1)    begin fails++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    tests++; if (out_valid !== 1'b0)   begin fails++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    tests++; if (out_data !== 32'h0)   begin fails++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    tests++; if (out_count !== 9'h0)   begin fails++; $display("FAIL reset_out_count: got %0d want 0", out_count); end
    tests++; if (out_ovf !== 1'b0)     begin fails++; $display("FAIL reset_out_ovf: got %0b want 0", out_ovf); end
  endtask

  task automatic test_three_ff_latency();
    logic [31:0] d; logic [8:0] c; logic o; bit to;
    int n;
    send_beat(24'hFFFFFF, 1'b0);
    send_beat(24'hFFFFFF, 1'b0);
    send_beat(24'hFFFFFF, 1'b1);
    // now one cycle after the last handshake
    n = 1;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    tests++; if (n !== 5) begin fails++; $display("FAIL latency: out_valid after %0d cycles want 5", n); end
    get_result(0, d, c, o, to);
    tests++; if (to || d !== 32'h02FFFFFD) begin fails++; $display("FAIL three_ff_data: got %h want 02fffffd", d); end
    tests++; if (to || c !== 9'd3)         begin fails++; $display("FAIL three_ff_count: got %0d want 3", c); end
    tests++; if (to || o !== 1'b0)         begin fails++; $display("FAIL three_ff_ovf: got %0b want 0", o); end
  endtask

  task automatic test_single();
    logic [31:0] d; logic [8:0] c; logic o; bit to;
    send_beat(24'h123456, 1'b1);
    get_result(0, d, c, o, to);
    tests++; if (to || d !== 32'h00123456) begin fails++; $display("FAIL single_data: got %h want 00123456", d); end
    tests++; if (to || c !== 9'd1)         begin fails++; $display("FAIL single_count: got %0d want 1", c); end
  endtask

  task automatic test_overflow(input int nops);
    logic [31:0] d; logic [8:0] c; logic o; bit to;
    logic [31:0] exp_sum = 0;
    for (int i = 0; i < nops; i++) begin
      send_beat(24'hFFFFFF, (i == nops - 1));
      exp_sum += 32'hFFFFFF;
    end
    get_result(0, d, c, o, to);
    tests++; if (to || d !== exp_sum)      begin fails++; $display("FAIL ovf%0d_data: got %h want %h", nops, d, exp_sum); end
    tests++; if (to || c !== 9'(nops))     begin fails++; $display("FAIL ovf%0d_count: got %0d want %0d", nops, c, nops); end
    tests++; if (to || o !== (nops > 256)) begin fails++; $display("FAIL ovf%0d_flag: got %0b want %0b", nops, o, nops > 256); end
  endtask

  task automatic test_stall();
    logic [31:0] d; logic [8:0] c; logic o; bit to;
    logic [31:0] held;
    int n = 0;
    send_beat(24'h00ABCD, 1'b0);
    send_beat(24'h000111, 1'b1);
    while (!out_valid && n < 20) begin step(); n++; end
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL stall_timeout: out_valid=%0b want 1", out_valid); end
    held = out_data;
    tests++; if (held !== 32'h0000ACDE) begin fails++; $display("FAIL stall_data: got %h want 0000acde", held); end
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if (out_data !== held || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        fails++;
        $display("FAIL stall_hold: data=%h ready=%0b valid=%0b want %h 0 1", out_data, in_ready, out_valid, held);
      end
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    send_beat(24'd1, 1'b0);
    send_beat(24'd2, 1'b1);
    get_result(0, d, c, o, to);
    tests++; if (to || d !== 32'd3 || c !== 9'd2) begin fails++; $display("FAIL stall_next: got %h/%0d want 3/2", d, c); end
  endtask

  task automatic test_bubbles();
    logic [31:0] d; logic [8:0] c; logic o; bit to;
    send_beat(24'd5, 1'b0);
    idle(1);
    send_beat(24'd7, 1'b1);
    idle(1);
    get_result(0, d, c, o, to);
    tests++; if (to || d !== 32'd12) begin fails++; $display("FAIL bubble_data: got %h want 12", d); end
    tests++; if (to || c !== 9'd2)   begin fails++; $display("FAIL bubble_count: got %0d want 2", c); end
  endtask

  task automatic test_reset_in_resolve();
    logic [31:0] d; logic [8:0] c; logic o; bit to;
    send_beat(24'h777777, 1'b0);
    send_beat(24'h0F0F0F, 1'b1);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL rst_resolve: valid=%0b ready=%0b want 0 1", out_valid, in_ready);
    end
    send_beat(24'd9, 1'b1);
    get_result(0, d, c, o, to);
    tests++; if (to || d !== 32'd9 || c !== 9'd1 || o !== 1'b0) begin
      fails++; $display("FAIL rst_resolve_next: got %h/%0d/%0b want 9/1/0", d, c, o);
    end
  endtask

  task automatic test_random();
    logic [31:0] d; logic [8:0] c; logic o; bit to;
    for (int p = 0; p < 25; p++) begin
      int len = $urandom_range(1, 8);
      logic [31:0] exp_sum = 0;
      for (int i = 0; i < len; i++) begin
        logic [23:0] x = 24'($urandom);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        send_beat(x, (i == len - 1));
        exp_sum += {8'h0, x};
      end
      get_result($urandom_range(0, 3), d, c, o, to);
      tests++;
      if (to || d !== exp_sum || c !== 9'(len) || o !== 1'b0) begin
        fails++;
        $display("FAIL random_pkt%0d: got %h/%0d/%0b want %h/%0d/0", p, d, c, o, exp_sum, len);
      end
    end
  endtask

  initial begin
    test_reset();
    test_three_ff_latency();
    test_single();
    test_overflow(256);
    test_overflow(257);
    test_stall();
    test_bubbles();
    test_reset_in_resolve();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/csa_accum.md
# csa_accum

Streaming multi-operand accumulator that sits directly downstream of the carry-save adder datapath. It keeps a packet's running total in redundant sum/carry form, folding one W-bit operand per cycle through a 3:2 compression row with no carry propagation. On the packet's last operand it resolves the redundant pair into a binary result. Resolution uses a chunked, multi-cycle carry-propagate adder, so the critical path stays at one CHUNK-bit add.

## Interface
- W, 24: operand width
- CW, 8: headroom bits; accumulator width A = W+CW; up to 2^CW operands per packet are exact
- CHUNK, 8: resolve adder width per cycle; A must be a multiple of CHUNK; NCH = A/CHUNK
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operand valid
- in_ready  out  1  block accepts operand
- in_data  in  W  unsigned operand
- in_last  in  1  final operand of packet
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  A  packet sum mod 2^A
- out_count  out  CW+1  operands accepted in packet, saturating at 2^(CW+1)-1
- out_ovf  out  1  more than 2^CW operands accepted (out_data wrapped)

## Operation
- States: ACC, RESOLVE, OUT.
- ACC:
  - in_ready=1.
  - On in_valid&in_ready: s <= s^c^x, c <= (maj(s,c,x))<<1, with x zero-extended to A bits. All widths truncate to A bits; the MSB carry is dropped.
  - Count increments, saturating.
  - With in_last set: go to RESOLVE, chunk index k=0, carry-in 0.
- RESOLVE:
  - in_ready=0.
  - Each cycle: {cy, r[k]} <= s[k] + c[k] + cy on CHUNK-bit slice k; k increments.
  - After slice NCH-1: go to OUT.
- OUT:
  - out_valid=1; out_data, out_count and out_ovf are held stable.
  - On out_ready: clear s, c, count and ovf; go to ACC.
- out_ovf is set when count reaches 2^CW+1. It is sticky for the packet.
- Single-operand packet (in_last on the first beat): out_data equals the zero-extended operand.
- in_last is ignored unless in_valid&in_ready.
- Reset, in any state: state=ACC; s, c, count, cy, k, ovf and result all cleared.
- Reset reset values: in_ready=1 from the first post-reset cycle; out_valid=0, out_data=0, out_count=0, out_ovf=0.

## Timing
- Throughput in ACC: one operand per cycle.
- Latency: the last-operand handshake happens in cycle t. out_valid is 1 in cycle t+NCH+1 (t+5 at defaults).
- Packet-to-packet gap: NCH+1 cycles minimum, plus any out_ready stall.
- in_ready is a registered function of state. It never depends combinationally on out_ready.
- The next packet's first operand is accepted no earlier than the cycle after the out handshake.
- Critical path:
  - ACC: one 3-input XOR/majority level.
  - RESOLVE: one CHUNK-bit add.

## Structure
- Package csa_pkg holds:
  - the state enum (ACC, RESOLVE, OUT);
  - localparams A = W+CW and NCH = A/CHUNK;
  - a width-check function, used for an elaboration-time error if A%CHUNK != 0.
- Sub-module csa_row: parameterised A-bit 3:2 compressor row, combinational. Inputs a, b, c; outputs ps and the shifted carry.
- Top level: FSM, s/c registers, chunk counter, resolve carry flop, result register, operand counter.

## Test plan
- Three operands 0xFFFFFF with last on the third: out_data=0x02FFFFFD, out_count=3, out_ovf=0; out_valid rises exactly 5 cycles after the last handshake.
- Single operand 0x123456 with last: out_data=0x00123456, out_count=1.
- 256 operands of 0xFFFFFF: out_data=0xFFFFFF00, out_ovf=0. With 257 operands: out_data=0x00FFFEFF, out_count=257, out_ovf=1.
- out_ready held low for 3 cycles in OUT:
  - out_data is stable and in_ready=0 throughout;
  - after the handshake, the next packet of 1 then 2 gives out_data=3, with no residue from the prior packet.
- in_valid toggling 1,0,1,0 with operands 5, 7 (last): out_data=12; idle cycles do not change s, c or count.
- rst asserted during RESOLVE (k=2):
  - next cycle out_valid=0 and in_ready=1;
  - a new packet of 9 then last gives out_data=9.
